mag_stats: RTL
==============

# mag_stats

Windowed statistics stage placed directly after the CORDIC magnitude pipeline. It consumes the unsigned Q16.16 magnitude stream, which has no backpressure and delivers at most one sample per cycle. Over each non-overlapping window of 2^LOG2_LEN samples it computes mean, maximum and minimum. It presents each window's results through a one-deep valid/ready output register, and flags any result lost to downstream stalls.

## Interface

- WIDTH, 32, magnitude width in bits; unsigned Q16.16 by default.
- LOG2_LEN, 4, log2 of window length; the window is 2^LOG2_LEN samples; legal range 1..8.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- valid_i  in  1  input sample strobe; no ready is returned, and every valid sample must be consumed.
- data_i  in  WIDTH  magnitude sample, unsigned.
- clear_i  in  1  synchronous abort of the partial window; also clears overrun_o.
- valid_o  out  1  result register holds an unaccepted window result.
- ready_i  in  1  downstream accepts the result when valid_o && ready_i.
- mean_o  out  WIDTH  window sum >> LOG2_LEN (truncating).
- max_o  out  WIDTH  largest sample in the window.
- min_o  out  WIDTH  smallest sample in the window.
- overrun_o  out  1  sticky flag: a completed window was discarded because the output register was full.

## Operation

- Accumulation state:
  - acc is WIDTH+LOG2_LEN bits wide and never overflows.
  - cnt is LOG2_LEN bits and counts samples in the current window.
  - run_max and run_min hold the running extremes.
- Reset values: acc=0, cnt=0, run_max=0, run_min=all-ones, valid_o=0, mean_o/max_o/min_o=0, overrun_o=0.
- Accepted sample (valid_i=1, clear_i=0, cnt != 2^LOG2_LEN-1):
  - acc += data_i, cnt++.
  - run_max = max(run_max, data_i), run_min = min(run_min, data_i).
  - Comparisons are unsigned.
- Completing sample (valid_i=1, clear_i=0, cnt == 2^LOG2_LEN-1):
  - Final values are formed combinationally, including data_i: sum=acc+data_i, plus max and min.
  - acc, cnt, run_max and run_min return to their reset values the same edge.
- Output FSM with two states:
  - EMPTY (valid_o=0): a completing sample loads the result registers and moves to FULL.
  - FULL (valid_o=1): outputs hold stable until a handshake.
  - Handshake without a completion returns to EMPTY.
  - Handshake in the same cycle as a completion loads the new result and stays FULL; no overrun.
  - A completion while FULL without a handshake discards the new result, keeps the old one, sets overrun_o=1 and stays FULL.
- clear_i=1:
  - Accumulation state returns to reset values, and a concurrent valid_i sample is discarded.
  - overrun_o is cleared.
  - The output register and FSM are unaffected, and a pending result may still be accepted.
- mean_o = sum[WIDTH+LOG2_LEN-1:LOG2_LEN], which always fits WIDTH bits.
- Deasserting rst_ni mid-window discards the partial window and any pending result. All state takes its reset value at that edge.

## Timing

- Latency: the completing sample sampled at edge N gives valid_o=1 and stable results after edge N.
- Throughput: one sample per cycle sustained. Input is never stalled.
- valid_o, once high, remains high with stable outputs until the cycle after valid_o && ready_i, unless reset occurs.
- ready_i is ignored while valid_o=0.
- overrun_o rises the edge after the discarding completion. It falls only on reset or clear_i.
- Gaps in valid_i have no effect; cnt holds.

## Test plan

All scenarios use LOG2_LEN=2 (window of 4) and WIDTH=32.

- **Basic window.** Drive samples 0x00010000, 0x00020000, 0x00030000 and 0x00060000 back-to-back with ready_i=1. Expected: valid_o=1 for exactly one cycle, the cycle after the 4th sample. Outputs are mean_o=0x00030000, max_o=0x00060000 and min_o=0x00010000.
- **Truncation and width.** Window 0,0,0,3 gives mean_o=0. Window of four 0xFFFFFFFF gives mean_o=max_o=min_o=0xFFFFFFFF, with no wrap.
- **Backpressure and overrun.** With ready_i=0, stream 8 samples (1..8 ×0x10000) with gaps.
  - After the first window: valid_o=1, mean=0x00028000.
  - After the second window: results are unchanged and overrun_o=1.
  - Then ready_i=1 for one cycle: valid_o=0.
- **Simultaneous accept and completion.** Window 1 is pending. The cycle window 2 completes, assert ready_i=1. Expected: valid_o stays 1, the outputs update to window 2 values, and overrun_o stays 0.
- **Clear mid-window.**
  - Send 2 samples of 0x00100000, then clear_i=1 with valid_i=1 (data 0x00500000), then 4 samples of 0x00020000.
  - Expected: one result with mean=max=min=0x00020000.
  - If overrun_o was set beforehand, it reads 0 after the clear.
- **Reset mid-operation.** Set up a pending result plus 3 samples of a partial window, then pulse rst_ni=0 for one cycle.
  - Expected: all outputs are 0 the next cycle.
  - A following 4-sample window of 0x00040000 yields mean 0x00040000, with no contribution from the partial window.

Source files
------------

// File: rtl/mag_stats_if.sv
// Sample stream in, windowed statistics result out, for the mag_stats stage.
// The block itself connects through the slave modport; the driver/consumer side uses master.
interface mag_stats_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic [WIDTH-1:0] data_i;
    logic             clear_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] mean_o;
    logic [WIDTH-1:0] max_o;
    logic [WIDTH-1:0] min_o;
    logic             overrun_o;

    modport slave (
        input  valid_i, data_i, clear_i, ready_i,
        output valid_o, mean_o, max_o, min_o, overrun_o
    );

    modport master (
        output valid_i, data_i, clear_i, ready_i,
        input  valid_o, mean_o, max_o, min_o, overrun_o
    );
endinterface

// File: rtl/mag_stats.sv
// Windowed mean/max/min over non-overlapping 2^LOG2_LEN sample windows of an unstallable
// magnitude stream, with a one-deep valid/ready result register and a sticky overrun flag.
module mag_stats #(
    parameter int WIDTH    = 32,
    parameter int LOG2_LEN = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    mag_stats_if.slave  bus
);
    localparam int AW = WIDTH + LOG2_LEN;

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [AW-1:0]       acc;
    logic [LOG2_LEN-1:0] cnt;
    logic [WIDTH-1:0]    run_max;
    logic [WIDTH-1:0]    run_min;
    logic [0:0]          state;

    logic [WIDTH-1:0]    mean_q;
    logic [WIDTH-1:0]    max_q;
    logic [WIDTH-1:0]    min_q;
    logic                overrun_q;

    logic                take;
    logic                last;
    logic                accept;
    logic [AW-1:0]       sum;
    logic [WIDTH-1:0]    fin_max;
    logic [WIDTH-1:0]    fin_min;

    // The completing sample is folded in combinationally so the result is ready on that edge.
    assign take    = bus.valid_i && !bus.clear_i;
    assign last    = take && (cnt == '1);
    assign accept  = (state == FULL) && bus.ready_i;
    assign sum     = acc + AW'(bus.data_i);
    assign fin_max = (bus.data_i > run_max) ? bus.data_i : run_max;
    assign fin_min = (bus.data_i < run_min) ? bus.data_i : run_min;

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous and covers every register; there is no memory array here.
        if (!rst_ni) begin
            acc       <= '0;
            cnt       <= '0;
            run_max   <= '0;
            run_min   <= '1;
            state     <= EMPTY;
            mean_q    <= '0;
            max_q     <= '0;
            min_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (bus.clear_i) begin
                acc       <= '0;
                cnt       <= '0;
                run_max   <= '0;
                run_min   <= '1;
                overrun_q <= 1'b0;
            end else if (bus.valid_i) begin
                if (last) begin
                    acc     <= '0;
                    cnt     <= '0;
                    run_max <= '0;
                    run_min <= '1;
                end else begin
                    acc     <= sum;
                    cnt     <= cnt + 1'b1;
                    run_max <= fin_max;
                    run_min <= fin_min;
                end
            end

            // A completion may only overwrite the register if it is empty or being drained now.
            if (last && (state == EMPTY || accept)) begin
                mean_q <= sum[AW-1:LOG2_LEN];
                max_q  <= fin_max;
                min_q  <= fin_min;
                state  <= FULL;
            end else if (last) begin
                overrun_q <= 1'b1;
            end else if (accept) begin
                state <= EMPTY;
            end
        end
    end

    assign bus.valid_o   = (state == FULL);
    assign bus.mean_o    = mean_q;
    assign bus.max_o     = max_q;
    assign bus.min_o     = min_q;
    assign bus.overrun_o = overrun_q;
endmodule
